// File: rtl/servant_rst_seq.sv
// servant_rst_seq: reset sequencer and watchdog for the servant SoC.
// Holds the active-high core reset for HOLD_CYCLES clock edges after power-on,
// a debounced button press, a software request or a watchdog expiry. A
// two-register Wishbone slave exposes the last reset cause and the watchdog.
// Only i_rst_n clears this block; the sequenced core reset never does.
module servant_rst_seq #(
    parameter int HOLD_CYCLES     = 2000000,
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter int WDT_WIDTH       = 24
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_btn,
    input  logic        i_wb_cyc,
    input  logic        i_wb_we,
    input  logic        i_wb_adr,
    input  logic [31:0] i_wb_dat,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack,
    output logic        o_rst,
    output logic [1:0]  o_cause
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES);
    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [HOLD_W-1:0]    HOLD_ZERO = HOLD_W'(0);
    localparam logic [HOLD_W-1:0]    HOLD_ONE  = HOLD_W'(1);
    localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [DEB_W-1:0]     DEB_ZERO  = DEB_W'(0);
    localparam logic [DEB_W-1:0]     DEB_ONE   = DEB_W'(1);
    localparam logic [DEB_W-1:0]     DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DEB_W-1:0]     DEB_MAX   = DEB_W'(DEBOUNCE_CYCLES);
    localparam logic [WDT_WIDTH-1:0] WDT_ZERO  = WDT_WIDTH'(0);
    localparam logic [WDT_WIDTH-1:0] WDT_ONE   = WDT_WIDTH'(1);

    localparam logic [1:0] CAUSE_POR = 2'd0;
    localparam logic [1:0] CAUSE_BTN = 2'd1;
    localparam logic [1:0] CAUSE_SW  = 2'd2;
    localparam logic [1:0] CAUSE_WDT = 2'd3;

    typedef enum logic {
        ST_ASSERT = 1'b0,
        ST_RUN    = 1'b1
    } state_t;

    // Packs the CTRL read word: cause in [1:0], watchdog enable in bit 8.
    function automatic logic [31:0] ctrl_word(input logic [1:0] cause, input logic en);
        logic [31:0] w;
        w      = 32'h0000_0000;
        w[1:0] = cause;
        w[8]   = en;
        return w;
    endfunction

    // Sequencer state
    state_t              state_r;
    state_t              state_nxt_s;
    logic [HOLD_W-1:0]   hold_cnt_r;
    logic [HOLD_W-1:0]   hold_nxt_s;
    logic                rst_r;
    logic [1:0]          cause_r;
    logic [1:0]          cause_nxt_s;
    logic                restart_s;

    // Button path
    logic                btn_meta_r;
    logic                btn_sync_r;
    logic [DEB_W-1:0]    deb_cnt_r;
    logic [DEB_W-1:0]    deb_nxt_s;
    logic                press_s;

    // Watchdog and software request
    logic                wdt_en_r;
    logic                wdt_en_nxt_s;
    logic [WDT_WIDTH-1:0] wdt_cnt_r;
    logic [WDT_WIDTH-1:0] wdt_cnt_nxt_s;
    logic                sw_req_r;
    logic                sw_req_nxt_s;
    logic                wdt_expire_s;
    logic                in_run_s;

    // Wishbone
    logic                ack_r;
    logic [31:0]         rdt_r;
    logic [31:0]         rdt_nxt_s;
    logic                access_s;
    logic                wr_ctrl_s;
    logic                wr_wdt_s;
    logic [31:0]         wdt_word_s;
    logic                unused_dat_s;

    assign in_run_s     = (state_r == ST_RUN);
    assign access_s     = i_wb_cyc & ~ack_r;
    // Writes are dropped while the core is held in reset.
    assign wr_ctrl_s    = access_s & i_wb_we & in_run_s & ~i_wb_adr;
    assign wr_wdt_s     = access_s & i_wb_we & in_run_s & i_wb_adr;
    // Expiry is checked on the already-zero count, so a kick landing on the
    // 1-to-0 edge reloads the counter before expiry is ever seen.
    assign wdt_expire_s = in_run_s & wdt_en_r & (wdt_cnt_r == WDT_ZERO);
    // Fires exactly once per high run: the count saturates past DEB_LAST.
    assign press_s      = btn_sync_r & (deb_cnt_r == DEB_LAST);
    assign wdt_word_s   = 32'(wdt_cnt_r);
    assign unused_dat_s = ^i_wb_dat;

    assign o_rst    = rst_r;
    assign o_cause  = cause_r;
    assign o_wb_ack = ack_r;
    assign o_wb_rdt = rdt_r;

    // Two-flop synchronizer for the asynchronous button input.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            btn_meta_r <= 1'b0;
            btn_sync_r <= 1'b0;
        end else begin
            btn_meta_r <= i_btn;
            btn_sync_r <= btn_meta_r;
        end
    end

    // Debounce count: consecutive synced-high cycles, saturating at the threshold.
    always_comb begin
        deb_nxt_s = deb_cnt_r;
        if (!btn_sync_r) begin
            deb_nxt_s = DEB_ZERO;
        end else if (deb_cnt_r != DEB_MAX) begin
            deb_nxt_s = deb_cnt_r + DEB_ONE;
        end else begin
            deb_nxt_s = deb_cnt_r;
        end
    end

    // Debounce counter register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            deb_cnt_r <= DEB_ZERO;
        end else begin
            deb_cnt_r <= deb_nxt_s;
        end
    end

    // Sequence control: next reset state, hold count and cause by event priority.
    always_comb begin
        state_nxt_s = state_r;
        hold_nxt_s  = hold_cnt_r;
        cause_nxt_s = cause_r;
        restart_s   = 1'b0;
        case (state_r)
            ST_ASSERT: begin
                if (press_s) begin
                    hold_nxt_s  = HOLD_ZERO;
                    cause_nxt_s = CAUSE_BTN;
                    restart_s   = 1'b1;
                end else if (hold_cnt_r == HOLD_LAST) begin
                    state_nxt_s = ST_RUN;
                    hold_nxt_s  = HOLD_ZERO;
                end else begin
                    hold_nxt_s = hold_cnt_r + HOLD_ONE;
                end
            end
            ST_RUN: begin
                if (press_s) begin
                    state_nxt_s = ST_ASSERT;
                    hold_nxt_s  = HOLD_ZERO;
                    cause_nxt_s = CAUSE_BTN;
                    restart_s   = 1'b1;
                end else if (wdt_expire_s) begin
                    state_nxt_s = ST_ASSERT;
                    hold_nxt_s  = HOLD_ZERO;
                    cause_nxt_s = CAUSE_WDT;
                    restart_s   = 1'b1;
                end else if (sw_req_r) begin
                    state_nxt_s = ST_ASSERT;
                    hold_nxt_s  = HOLD_ZERO;
                    cause_nxt_s = CAUSE_SW;
                    restart_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: begin
                state_nxt_s = ST_ASSERT;
                hold_nxt_s  = HOLD_ZERO;
            end
        endcase
    end

    // Sequencer registers; o_rst is registered from the next state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r    <= ST_ASSERT;
            hold_cnt_r <= HOLD_ZERO;
            rst_r      <= 1'b1;
            cause_r    <= CAUSE_POR;
        end else begin
            state_r    <= state_nxt_s;
            hold_cnt_r <= hold_nxt_s;
            rst_r      <= (state_nxt_s == ST_ASSERT);
            cause_r    <= cause_nxt_s;
        end
    end

    // Watchdog, enable and software-request updates; a starting sequence wins.
    always_comb begin
        wdt_en_nxt_s  = wdt_en_r;
        wdt_cnt_nxt_s = wdt_cnt_r;
        sw_req_nxt_s  = 1'b0;
        if (wr_ctrl_s) begin
            wdt_en_nxt_s = i_wb_dat[8] & ~i_wb_dat[31];
            sw_req_nxt_s = i_wb_dat[31];
        end else begin
            wdt_en_nxt_s = wdt_en_r;
        end
        if (wr_wdt_s) begin
            wdt_cnt_nxt_s = i_wb_dat[WDT_WIDTH-1:0];
        end else if (in_run_s && wdt_en_r && (wdt_cnt_r != WDT_ZERO)) begin
            wdt_cnt_nxt_s = wdt_cnt_r - WDT_ONE;
        end else begin
            wdt_cnt_nxt_s = wdt_cnt_r;
        end
        if (restart_s) begin
            wdt_en_nxt_s = 1'b0;
            sw_req_nxt_s = 1'b0;
        end else begin
            sw_req_nxt_s = sw_req_nxt_s;
        end
    end

    // Watchdog registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wdt_en_r  <= 1'b0;
            wdt_cnt_r <= WDT_ZERO;
            sw_req_r  <= 1'b0;
        end else begin
            wdt_en_r  <= wdt_en_nxt_s;
            wdt_cnt_r <= wdt_cnt_nxt_s;
            sw_req_r  <= sw_req_nxt_s;
        end
    end

    // Read data mux: only reads update the returned word.
    always_comb begin
        rdt_nxt_s = rdt_r;
        if (access_s && !i_wb_we) begin
            if (i_wb_adr) begin
                rdt_nxt_s = wdt_word_s;
            end else begin
                rdt_nxt_s = ctrl_word(cause_r, wdt_en_r);
            end
        end else begin
            rdt_nxt_s = rdt_r;
        end
    end

    // Wishbone ack and read data registers: one ack per access.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ack_r <= 1'b0;
            rdt_r <= 32'h0000_0000;
        end else begin
            ack_r <= access_s;
            rdt_r <= rdt_nxt_s;
        end
    end

endmodule

// File: doc/servant_rst_seq.md
Name: servant_rst_seq

Overview:
- Reset sequencer and watchdog for the servant SoC. It replaces the ad-hoc power-on counter in board top levels.
- Generates the active-high core reset with a programmable hold time. The reset is re-armed by a debounced board button, a software request, or watchdog expiry.
- Exposes a small Wishbone slave so firmware can read the last reset cause and service the watchdog.
- Sits between the board pins and servant's wb_rst. It is clocked by the same clock as the SoC.

Parameters:
- HOLD_CYCLES, 2000000: number of clock cycles o_rst stays high on each reset sequence (minimum 2).
- DEBOUNCE_CYCLES, 65536: consecutive stable-high cycles required to accept a button press (minimum 1).
- WDT_WIDTH, 24: watchdog counter width (maximum 32).

Ports:
- i_clk, in, 1: system clock, shared with servant wb_clk.
- i_rst_n, in, 1: reset, asynchronous active-low. Deassertion is synchronous to i_clk (provided upstream).
- i_btn, in, 1: board reset button, active-high, asynchronous, bouncing.
- i_wb_cyc, in, 1: Wishbone cycle/strobe.
- i_wb_we, in, 1: write enable.
- i_wb_adr, in, 1: register select (0 = CTRL, 1 = WDT). Driven from SoC address bit 2.
- i_wb_dat, in, 32: write data.
- o_wb_rdt, out, 32: read data.
- o_wb_ack, out, 1: cycle acknowledge.
- o_rst, out, 1: active-high core reset to servant.
- o_cause, out, 2: last reset cause (0 POR, 1 button, 2 software, 3 watchdog).

Behaviour:
- Reset values while i_rst_n is low:
  - o_rst=1, o_cause=0, o_wb_ack=0, o_wb_rdt=0.
  - wdt_en=0, wdt_cnt=0, hold counter=0, state=ASSERT.
  - Button synchronizer and debounce counter cleared.
- The block is never reset by o_rst. Only i_rst_n clears it; o_cause survives sequenced resets.
- State ASSERT:
  - o_rst=1. The hold counter increments every cycle.
  - When the counter equals HOLD_CYCLES-1, the next state is RUN and o_rst goes 0 on that edge.
  - o_rst is therefore high for exactly HOLD_CYCLES rising edges after entry (or after i_rst_n release).
- State RUN: o_rst=0. A reset event moves to ASSERT on the next edge: o_rst=1, hold counter=0, wdt_en=0, o_cause updated.
- Reset events and their priority when simultaneous (highest first):
  - Button press (cause 1).
  - Watchdog expiry (cause 3).
  - Software request (cause 2).
- Button handling:
  - i_btn passes through a 2-flop synchronizer.
  - The debounce counter counts consecutive synced-high cycles and clears on any low.
  - A press fires once when the count reaches DEBOUNCE_CYCLES.
  - No further press fires until the synced input has been low for at least 1 cycle.
- Button press during ASSERT restarts the hold counter at 0 and sets o_cause=1.
- Wishbone handshake:
  - o_wb_ack <= i_wb_cyc & ~o_wb_ack, giving exactly one ack per access with one cycle of latency.
  - Writes take effect on the ack edge. o_wb_rdt is registered on the same edge and holds until the next read.
  - Accesses during ASSERT are acked; writes are ignored.
- CTRL register, read: bits[1:0]=o_cause, bit8=wdt_en, all other bits 0.
- CTRL register, write:
  - bit8 loads wdt_en.
  - bit31=1 raises a software reset event on the following edge.
  - If bit31 and bit8 are both set in one write, the reset wins and wdt_en ends 0.
- WDT register, read: zero-extended wdt_cnt.
- WDT register, write: wdt_cnt <= i_wb_dat[WDT_WIDTH-1:0] (kick/reload). Upper bits are ignored.
- Watchdog:
  - In RUN with wdt_en=1 and wdt_cnt nonzero, wdt_cnt decrements by 1 per cycle.
  - It expires when wdt_cnt==0 and wdt_en=1, including when wdt_en is written 1 while the count is 0.
  - A kick on the same edge as the 1-to-0 transition reloads the counter and wins; no expiry occurs.
  - The counter never wraps below 0.
  - wdt_cnt holds its value in ASSERT and while disabled.
- i_rst_n asserted mid-sequence aborts immediately. On release a fresh full sequence runs with o_cause=0.

Test Plan (HOLD_CYCLES=16, DEBOUNCE_CYCLES=4, WDT_WIDTH=8):
- POR: release i_rst_n -> o_rst high for exactly 16 edges then 0. o_cause=0. CTRL reads 0x0.
- Button:
  - 3-cycle glitches on i_btn -> no reset.
  - Hold i_btn high 10 cycles -> one sequence, o_cause=1, o_rst high 16 cycles.
  - Keep holding -> no second sequence.
- Software reset: write CTRL=0x80000000 -> o_rst rises 2 edges after cyc, high 16 cycles. CTRL then reads 0x2.
- Watchdog expiry: write WDT=5, then CTRL=0x100 -> countdown to 0, o_rst rises, o_cause=3, wdt_en reads 0 after release.
- Watchdog kick: kick WDT=5 every 4 cycles for 100 cycles -> o_rst stays 0. WDT reads decrease monotonically between kicks.
- Priority and abort:
  - Button press on the same edge as watchdog expiry -> o_cause=1.
  - i_rst_n pulsed low mid-ASSERT -> o_cause=0 and a full 16-cycle hold after release.
